// File: rtl/micro_seq_pkg.sv
// Shared types and microword field layout for the microprogram sequencer.
// Field offsets are functions so every width parameter set derives one layout.
package micro_seq_pkg;

    typedef enum logic [2:0] {
        OP_CONT  = 3'd0,
        OP_JMP   = 3'd1,
        OP_CJMP  = 3'd2,
        OP_DISP  = 3'd3,
        OP_CALL  = 3'd4,
        OP_RET   = 3'd5,
        OP_LDCNT = 3'd6,
        OP_LOOP  = 3'd7
    } op_e;

    typedef enum logic {
        ST_RST = 1'b0,
        ST_RUN = 1'b1
    } state_e;

    // Microword layout, MSB to LSB: OP[2:0], INV, CSEL, TGT, CTL
    function automatic int tgt_lo(input int cw);
        return cw;
    endfunction

    function automatic int csel_lo(input int aw, input int cw);
        return aw + cw;
    endfunction

    function automatic int inv_bit(input int aw, input int cw, input int csw);
        return csw + aw + cw;
    endfunction

    function automatic int op_lo(input int aw, input int cw, input int csw);
        return 1 + csw + aw + cw;
    endfunction

endpackage

// File: rtl/micro_seq_if.sv
// Microcode ROM bus: the sequencer drives the address, the ROM returns the word
// combinationally in the same cycle.
interface micro_seq_if #(
    parameter int AW = 8,
    parameter int UW = 49
);
    logic [AW-1:0] UADDR;
    logic [UW-1:0] UDATA;

    modport master (output UADDR, input UDATA);
    modport slave  (input UADDR, output UDATA);
endinterface

// File: rtl/uret_stack.sv
// Return-address LIFO. Push on full and pop on empty are ignored; the caller
// decides whether those are faults.
module uret_stack #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] top_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [LW-1:0] lvl_q;
    logic [LW-1:0] top_ix;

    assign full_o  = (lvl_q == LW'(DEPTH));
    assign empty_o = (lvl_q == '0);
    assign level_o = lvl_q;
    assign top_ix  = lvl_q - LW'(1);
    assign top_o   = mem_q[top_ix[IW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lvl_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i && !full_o) begin
            mem_q[lvl_q[IW-1:0]] <= din_i;
            lvl_q                <= lvl_q + LW'(1);
        end else if (pop_i && !empty_o) begin
            lvl_q <= lvl_q - LW'(1);
        end
    end
endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: next-address selection, loop counter and MIR; the
// return stack lives in uret_stack.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int AW    = 8,
    parameter int CW    = 34,
    parameter int NCOND = 8,
    parameter int CSW   = 3,
    parameter int DEPTH = 4,
    parameter int LCW   = 6
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    micro_seq_if.master            rom,
    input  logic [NCOND-1:0]       COND,
    input  logic [AW-1:0]          DISP_ADDR,
    output logic [CW-1:0]          CU,
    output logic [$clog2(DEPTH):0] SP,
    output logic                   ERR
);
    localparam int UW      = 4 + CSW + AW + CW;
    localparam int TGT_LO  = tgt_lo(CW);
    localparam int CSEL_LO = csel_lo(AW, CW);
    localparam int INV_BIT = inv_bit(AW, CW, CSW);
    localparam int OP_LO   = op_lo(AW, CW, CSW);

    logic [UW-1:0]  mir_q;
    logic [AW-1:0]  upc_q, uaddr_d, inc, tgt, stk_top;
    logic [LCW-1:0] lc_q, lc_d;
    logic           err_q, err_d;
    state_e         state_q;
    op_e            op;
    logic [CSW-1:0] csel;
    logic           cond_raw, t, push, pop, full, empty;

    assign op   = op_e'(mir_q[OP_LO +: 3]);
    assign csel = mir_q[CSEL_LO +: CSW];
    assign tgt  = mir_q[TGT_LO +: AW];
    assign inc  = upc_q + AW'(1);
    assign CU   = mir_q[CW-1:0];
    assign ERR  = err_q;

    // Selects beyond the populated condition inputs read as 0
    always_comb begin
        cond_raw = 1'b0;
        for (int i = 0; i < NCOND; i++)
            if (csel == CSW'(i)) cond_raw = COND[i];
    end
    assign t = cond_raw ^ mir_q[INV_BIT];

    always_comb begin
        uaddr_d = '0;
        lc_d    = lc_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (state_q == ST_RUN) begin
            case (op)
                OP_CONT:  uaddr_d = inc;
                OP_JMP:   uaddr_d = tgt;
                OP_CJMP:  uaddr_d = t ? tgt : inc;
                OP_DISP:  uaddr_d = DISP_ADDR;
                OP_CALL: begin
                    uaddr_d = tgt;
                    if (full) err_d = 1'b1;
                    else      push  = 1'b1;
                end
                OP_RET: begin
                    if (empty) err_d = 1'b1;
                    else begin
                        pop     = 1'b1;
                        uaddr_d = stk_top;
                    end
                end
                OP_LDCNT: begin
                    lc_d    = tgt[LCW-1:0];
                    uaddr_d = inc;
                end
                OP_LOOP: begin
                    if (lc_q != '0) begin
                        lc_d    = lc_q - LCW'(1);
                        uaddr_d = tgt;
                    end else begin
                        uaddr_d = inc;
                    end
                end
                default:  uaddr_d = inc;
            endcase
        end
    end

    assign rom.UADDR = uaddr_d;

    uret_stack #(.DW(AW), .DEPTH(DEPTH)) u_stack (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (inc),
        .top_o   (stk_top),
        .full_o  (full),
        .empty_o (empty),
        .level_o (SP)
    );

    // In ST_RST uaddr_d is 0, so the first load fetches address 0 into MIR
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mir_q   <= '0;
            upc_q   <= '0;
            lc_q    <= '0;
            err_q   <= 1'b0;
            state_q <= ST_RST;
        end else begin
            mir_q   <= rom.UDATA;
            upc_q   <= uaddr_d;
            lc_q    <= lc_d;
            err_q   <= err_d;
            state_q <= ST_RUN;
        end
    end
endmodule
